// File: rtl/layer_pkg.sv
// Shared types and default sizing for the spiking-layer sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package layer_pkg;

  localparam int NUM_SPIKES  = 64;
  localparam int TIME_PERIOD = 8;
  localparam int LOG_T       = 3;
  localparam int LOG_N       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } seq_state_t;

  typedef logic [LOG_T:0] spike_time_t;
  typedef logic [LOG_N:0] neuron_idx_t;

endpackage

// File: rtl/period_counter.sv
// Time-step counter for one sample period: counts 0..TIME_PERIOD-1 while enabled, then wraps.
// Latency: count changes one cycle after en; tc is combinational from the count.
// Backpressure: none; start forces the count back to period start.
module period_counter #(
  parameter int TIME_PERIOD = 8,
  parameter int LOG_T       = 3
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           start,
  input  logic           en,
  output logic [LOG_T:0] count,
  output logic           tc
);

  localparam logic [LOG_T:0] LAST = (LOG_T+1)'(TIME_PERIOD - 1);

  // Advance the time step; wrapping at LAST keeps the count at 0 whenever idle.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + (LOG_T+1)'(1);
    end
  end

  assign tc = (count == LAST);

endmodule

// File: rtl/layer_sequencer.sv
// Sequences one spiking layer through sample periods and returns the winner of inference samples.
// Latency: accept at edge k -> time 0 in cycle k+1 -> result valid from cycle k+TIME_PERIOD+1.
// Backpressure: in_ready only in IDLE; result held until res_ready. LAYER_SEQ_PERF_EN adds perf counters.
module layer_sequencer #(
  parameter int NUM_SPIKES  = layer_pkg::NUM_SPIKES,
  parameter int TIME_PERIOD = layer_pkg::TIME_PERIOD,
  parameter int LOG_T       = layer_pkg::LOG_T,
  parameter int LOG_N       = layer_pkg::LOG_N
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_train,
  input  logic [NUM_SPIKES*(LOG_T+1)-1:0] in_spike_times,
  output logic [LOG_T:0]                lyr_time_val,
  output logic [NUM_SPIKES*(LOG_T+1)-1:0] lyr_spike_times,
  output logic                          lyr_training,
  input  logic [LOG_N:0]                lyr_winning_neuron,
  input  logic [LOG_T:0]                lyr_output_spike_time,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [LOG_N:0]                res_neuron,
  output logic [LOG_T:0]                res_spike_time,
  output logic                          res_nofire
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                   perf_samples,
  output logic [31:0]                   perf_nofire
`endif
);

  import layer_pkg::*;

  // A layer spike time at or beyond the period length means nothing fired.
  localparam logic [LOG_T:0] NOFIRE_T = (LOG_T+1)'(TIME_PERIOD);

  seq_state_t state, state_nxt;
  logic       train_flag;
  logic       accept;
  logic       capture;
  logic       cnt_en;
  logic       tc;

  period_counter #(
    .TIME_PERIOD (TIME_PERIOD),
    .LOG_T       (LOG_T)
  ) u_period_counter (
    .clk   (clk),
    .rst_l (rst_l),
    .start (accept),
    .en    (cnt_en),
    .count (lyr_time_val),
    .tc    (tc)
  );

  // State register; reset lands in IDLE so in_ready reads 1 during reset.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    state_nxt    = state;
    in_ready     = 1'b0;
    res_valid    = 1'b0;
    lyr_training = 1'b0;
    cnt_en       = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        lyr_training = train_flag;
        cnt_en       = 1'b1;
        if (tc) begin
          if (train_flag) begin
            state_nxt = IDLE;
          end else begin
            capture   = 1'b1;
            state_nxt = RESULT;
          end
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample latch on accept and winner capture at the end of an inference period.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lyr_spike_times <= '0;
      train_flag      <= 1'b0;
      res_neuron      <= '0;
      res_spike_time  <= '0;
      res_nofire      <= 1'b0;
    end else begin
      if (accept) begin
        lyr_spike_times <= in_spike_times;
        train_flag      <= in_train;
      end
      if (capture) begin
        res_neuron     <= lyr_winning_neuron;
        res_spike_time <= lyr_output_spike_time;
        res_nofire     <= (lyr_output_spike_time >= NOFIRE_T);
      end
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  // Saturating counts of accepted samples and of no-fire results.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      perf_samples <= '0;
      perf_nofire  <= '0;
    end else begin
      if (accept && (perf_samples != '1)) begin
        perf_samples <= perf_samples + 32'd1;
      end
      if (capture && (lyr_output_spike_time >= NOFIRE_T) && (perf_nofire != '1)) begin
        perf_nofire <= perf_nofire + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: reset, inference, training, no-fire, stall, hold-valid, mid-run reset.
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: result stall exercised with res_ready held low for 20 cycles.
module tb_layer_sequencer;

  localparam int NS = 64;
  localparam int LT = 3;
  localparam int LN = 3;
  localparam int SW = NS * (LT + 1);

  logic          clk = 1'b0;
  logic          rst_l;
  logic          in_valid;
  logic          in_ready;
  logic          in_train;
  logic [SW-1:0] in_spike_times;
  logic [LT:0]   lyr_time_val;
  logic [SW-1:0] lyr_spike_times;
  logic          lyr_training;
  logic [LN:0]   lyr_winning_neuron;
  logic [LT:0]   lyr_output_spike_time;
  logic          res_valid;
  logic          res_ready;
  logic [LN:0]   res_neuron;
  logic [LT:0]   res_spike_time;
  logic          res_nofire;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]   perf_samples;
  logic [31:0]   perf_nofire;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [SW-1:0] sp_a;
  logic [SW-1:0] sp_b;

  always #5 clk = ~clk;

  layer_sequencer #(
    .NUM_SPIKES  (NS),
    .TIME_PERIOD (8),
    .LOG_T       (LT),
    .LOG_N       (LN)
  ) dut (
    .clk                   (clk),
    .rst_l                 (rst_l),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .in_train              (in_train),
    .in_spike_times        (in_spike_times),
    .lyr_time_val          (lyr_time_val),
    .lyr_spike_times       (lyr_spike_times),
    .lyr_training          (lyr_training),
    .lyr_winning_neuron    (lyr_winning_neuron),
    .lyr_output_spike_time (lyr_output_spike_time),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_neuron            (res_neuron),
    .res_spike_time        (res_spike_time),
    .res_nofire            (res_nofire)
`ifdef LAYER_SEQ_PERF_EN
    ,
    .perf_samples          (perf_samples),
    .perf_nofire           (perf_nofire)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_l                 = 1'b1;
    in_valid              = 1'b0;
    in_train              = 1'b0;
    in_spike_times        = '0;
    lyr_winning_neuron    = '0;
    lyr_output_spike_time = '0;
    res_ready             = 1'b0;

    // Reset state
    #2 rst_l = 1'b0;
    #20;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_time_val", 32'(lyr_time_val), 32'd0);
    chk("rst_training", 32'(lyr_training), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_neuron", 32'(res_neuron), 32'd0);
    chk("rst_res_time", 32'(res_spike_time), 32'd0);
    chk("rst_res_nofire", 32'(res_nofire), 32'd0);
    chk_vec("rst_spikes", lyr_spike_times, '0);
    rst_l = 1'b1;
    tick;

    // Inference sample: winner 5 at time 4
    sp_a = {64{4'h3}};
    in_spike_times        = sp_a;
    in_valid              = 1'b1;
    in_train              = 1'b0;
    lyr_winning_neuron    = 4'd5;
    lyr_output_spike_time = 4'd4;
    chk("inf_ready_pre", 32'(in_ready), 32'd1);
    tick;
    in_valid       = 1'b0;
    in_spike_times = '0;
    chk("inf_ready_run", 32'(in_ready), 32'd0);
    chk("inf_tv0", 32'(lyr_time_val), 32'd0);
    chk("inf_training", 32'(lyr_training), 32'd0);
    chk_vec("inf_spikes", lyr_spike_times, sp_a);
    for (int i = 1; i < 8; i++) begin
      tick;
      chk("inf_tv", 32'(lyr_time_val), 32'(i));
      chk("inf_no_res", 32'(res_valid), 32'd0);
    end
    tick;
    chk("inf_res_valid", 32'(res_valid), 32'd1);
    chk("inf_res_neuron", 32'(res_neuron), 32'd5);
    chk("inf_res_time", 32'(res_spike_time), 32'd4);
    chk("inf_res_nofire", 32'(res_nofire), 32'd0);
    chk("inf_tv_wrap", 32'(lyr_time_val), 32'd0);
    chk("inf_ready_res", 32'(in_ready), 32'd0);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("inf_done_valid", 32'(res_valid), 32'd0);
    chk("inf_done_ready", 32'(in_ready), 32'd1);

    // Training sample: no result, back to IDLE after the period
    sp_a = {64{4'h2}};
    in_spike_times = sp_a;
    in_train       = 1'b1;
    in_valid       = 1'b1;
    tick;
    in_valid = 1'b0;
    in_train = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("trn_training", 32'(lyr_training), 32'd1);
      chk("trn_tv", 32'(lyr_time_val), 32'(i));
      chk("trn_no_res", 32'(res_valid), 32'd0);
      tick;
    end
    chk("trn_end_training", 32'(lyr_training), 32'd0);
    chk("trn_end_ready", 32'(in_ready), 32'd1);
    chk("trn_end_no_res", 32'(res_valid), 32'd0);

    // Inference with layer time 8 -> no-fire
    in_spike_times        = {64{4'h1}};
    lyr_winning_neuron    = 4'd2;
    lyr_output_spike_time = 4'd8;
    in_valid              = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (8) tick;
    chk("nf_res_valid", 32'(res_valid), 32'd1);
    chk("nf_res_nofire", 32'(res_nofire), 32'd1);
    chk("nf_res_time", 32'(res_spike_time), 32'd8);
    chk("nf_res_neuron", 32'(res_neuron), 32'd2);

    // Result stall: res_ready low for 20 cycles, layer outputs and upstream change
    lyr_winning_neuron    = 4'd7;
    lyr_output_spike_time = 4'd1;
    in_spike_times        = {64{4'hC}};
    in_valid              = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("stall_valid", 32'(res_valid), 32'd1);
      chk("stall_neuron", 32'(res_neuron), 32'd2);
      chk("stall_time", 32'(res_spike_time), 32'd8);
      chk("stall_nofire", 32'(res_nofire), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk_vec("stall_spikes", lyr_spike_times, {64{4'h1}});
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("stall_done_valid", 32'(res_valid), 32'd0);
    chk("stall_done_ready", 32'(in_ready), 32'd1);
    chk("stall_done_tv", 32'(lyr_time_val), 32'd0);

    // in_valid held high with data changing during RUN
    sp_a = {32{8'h5A}};
    sp_b = {32{8'hA5}};
    in_spike_times = sp_a;
    in_train       = 1'b1;
    in_valid       = 1'b1;
    tick;
    in_spike_times = sp_b;
    for (int i = 0; i < 8; i++) begin
      chk_vec("hold_spikes", lyr_spike_times, sp_a);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      tick;
    end
    chk("hold_idle_ready", 32'(in_ready), 32'd1);
    chk_vec("hold_idle_spikes", lyr_spike_times, sp_a);
    tick;
    in_valid = 1'b0;
    chk_vec("hold_second_spikes", lyr_spike_times, sp_b);
    chk("hold_second_tv", 32'(lyr_time_val), 32'd0);
    chk("hold_second_ready", 32'(in_ready), 32'd0);
    chk("hold_second_training", 32'(lyr_training), 32'd1);

    // Reset mid-RUN at time 4
    repeat (4) tick;
    chk("mid_tv4", 32'(lyr_time_val), 32'd4);
    chk("mid_training", 32'(lyr_training), 32'd1);
    #2 rst_l = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_tv", 32'(lyr_time_val), 32'd0);
    chk("mid_rst_training", 32'(lyr_training), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_res_neuron", 32'(res_neuron), 32'd0);
    chk("mid_rst_res_time", 32'(res_spike_time), 32'd0);
    chk("mid_rst_res_nofire", 32'(res_nofire), 32'd0);
    chk_vec("mid_rst_spikes", lyr_spike_times, '0);
    #2 rst_l = 1'b1;
    tick;
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    chk("post_rst_tv", 32'(lyr_time_val), 32'd0);

    // Clean inference after reset; time 7 is the last firing time
    sp_a = {64{4'h7}};
    in_spike_times        = sp_a;
    in_train              = 1'b0;
    lyr_winning_neuron    = 4'd3;
    lyr_output_spike_time = 4'd7;
    in_valid              = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("clean_tv0", 32'(lyr_time_val), 32'd0);
    chk("clean_training", 32'(lyr_training), 32'd0);
    chk_vec("clean_spikes", lyr_spike_times, sp_a);
    repeat (7) tick;
    chk("clean_tv7", 32'(lyr_time_val), 32'd7);
    chk("clean_no_res", 32'(res_valid), 32'd0);
    tick;
    chk("clean_res_valid", 32'(res_valid), 32'd1);
    chk("clean_res_neuron", 32'(res_neuron), 32'd3);
    chk("clean_res_time", 32'(res_spike_time), 32'd7);
    chk("clean_res_nofire", 32'(res_nofire), 32'd0);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk("clean_done_valid", 32'(res_valid), 32'd0);
    chk("clean_done_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
